// File: rtl/seq_divider_32x16_if.sv
// Handshake/data bundle for the sequential 32/16 divider.
// master: issues start with dividend/divisor, observes busy/done and results.
// slave : the divider itself.
//   start      request a division (sampled on rising clk)
//   dividend   2*DW-bit unsigned dividend
//   divisor    DW-bit unsigned divisor
//   busy       division in progress
//   done       one-cycle pulse, results valid
//   quotient   DW-bit registered quotient
//   remainder  DW-bit registered remainder
//   ovf        divide-by-zero or quotient too wide, valid with done
interface seq_divider_32x16_if #(
    parameter int DW = 16
);
    logic              start;
    logic [2*DW-1:0]   dividend;
    logic [DW-1:0]     divisor;
    logic              busy;
    logic              done;
    logic [DW-1:0]     quotient;
    logic [DW-1:0]     remainder;
    logic              ovf;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, ovf
    );
endinterface

// File: rtl/seq_divider_32x16.sv
// Sequential restoring divider, 2*DW-bit dividend by DW-bit divisor,
// one quotient bit per clock (DW steps). Overflow (zero divisor or a
// quotient wider than DW bits) is detected at acceptance and completes
// on the next cycle without iterating.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    seq_divider_32x16_if slave modport (start/operands in,
//          busy/done/quotient/remainder/ovf out)
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for start
// CALC   | DW restoring steps in progress, busy high
// DONE   | results valid for one cycle, done high; start accepted here
module seq_divider_32x16 #(
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_divider_32x16_if.slave   bus
);
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]  r_q, r_d;
    logic [DW-1:0]  s_q, s_d;
    logic [DW-1:0]  div_q, div_d;
    logic [DW-1:0]  quo_q, quo_d;
    logic [DW-1:0]  rem_q, rem_d;
    logic           ovf_q, ovf_d;

    logic           accept;
    logic           in_ovf;
    logic [DW:0]    t;
    logic [DW-1:0]  t_sub;
    logic           qbit;
    logic [DW-1:0]  r_step;
    logic [DW-1:0]  s_step;

    // Zero divisor is also caught by the high-half compare, but kept explicit.
    assign accept = bus.start && (state_q == S_IDLE || state_q == S_DONE);
    assign in_ovf = (bus.divisor == '0) || (bus.dividend[2*DW-1:DW] >= bus.divisor);

    // 17-bit compare so the shifted partial remainder never wraps; the
    // difference itself always fits in DW bits when it is taken.
    assign t      = {r_q, s_q[DW-1]};
    assign qbit   = (t >= {1'b0, div_q});
    assign t_sub  = t[DW-1:0] - div_q;
    assign r_step = qbit ? t_sub : t[DW-1:0];
    assign s_step = {s_q[DW-2:0], qbit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            s_q     <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            s_q     <= s_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = in_ovf ? S_DONE : S_CALC;
            S_CALC:  if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  begin
                if (accept) state_d = in_ovf ? S_DONE : S_CALC;
                else        state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: results only change at completion so they hold across a new start.
    always_comb begin
        cnt_d = cnt_q;
        r_d   = r_q;
        s_d   = s_q;
        div_d = div_q;
        quo_d = quo_q;
        rem_d = rem_q;
        ovf_d = ovf_q;
        if (accept) begin
            div_d = bus.divisor;
            cnt_d = CW'(DW - 1);
            if (in_ovf) begin
                quo_d = '1;
                rem_d = '0;
                ovf_d = 1'b1;
            end else begin
                r_d = bus.dividend[2*DW-1:DW];
                s_d = bus.dividend[DW-1:0];
            end
        end else if (state_q == S_CALC) begin
            r_d   = r_step;
            s_d   = s_step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
                quo_d = s_step;
                rem_d = r_step;
                ovf_d = 1'b0;
            end
        end
    end

    always_comb begin
        bus.busy      = (state_q == S_CALC);
        bus.done      = (state_q == S_DONE);
        bus.quotient  = quo_q;
        bus.remainder = rem_q;
        bus.ovf       = ovf_q;
    end
endmodule

// File: tb/tb_seq_divider_32x16.sv
module tb_seq_divider_32x16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_divider_32x16_if #(.DW(16)) bus ();
    seq_divider_32x16 #(.DW(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] dvd;
        logic [15:0] dvs;
        logic [15:0] q;
        logic [15:0] r;
        logic        ovf;
        int          acc_cyc;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [15:0] last_q;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: plain integer division; overflow when the true quotient
    // does not fit in 16 bits or the divisor is zero.
    function automatic exp_t model(input logic [31:0] a, input logic [15:0] b, input int acc);
        exp_t e;
        longint unsigned la, lb, lq;
        la = a;
        lb = b;
        e.dvd = a;
        e.dvs = b;
        e.acc_cyc = acc;
        if (lb == 0) e.ovf = 1'b1;
        else begin
            lq = la / lb;
            e.ovf = (lq > 65535);
        end
        if (e.ovf) begin
            e.q = 16'hFFFF;
            e.r = 16'h0000;
            e.done_cyc = acc;
        end else begin
            e.q = 16'(la / lb);
            e.r = 16'(la % lb);
            e.done_cyc = acc + 16;
        end
        return e;
    endfunction

    // Monitor / scoreboard checker
    always @(negedge clk) begin
        if (rst_n) begin
            bit exp_busy;
            exp_t e;
            exp_busy = (sb.size() > 0) && !sb[0].ovf && (cyc >= sb[0].acc_cyc) &&
                       (cyc <= sb[0].acc_cyc + 15);
            check("busy", {63'd0, bus.busy}, {63'd0, exp_busy});
            if (bus.done) begin
                if (sb.size() == 0) check("spurious_done", 64'd1, 64'd0);
                else begin
                    e = sb.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e.done_cyc));
                    check("quotient", 64'(bus.quotient), 64'(e.q));
                    check("remainder", 64'(bus.remainder), 64'(e.r));
                    check("ovf", 64'(bus.ovf), 64'(e.ovf));
                    last_q = e.q;
                    if (!e.ovf) begin
                        check("identity", 64'(32'(bus.quotient) * 32'(e.dvs) + 32'(bus.remainder)),
                              64'(e.dvd));
                        check("rem_lt_div", {63'd0, (bus.remainder < e.dvs)}, 64'd1);
                    end
                end
            end else if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
                check("done_missing", 64'(cyc), 64'(sb[0].done_cyc));
                void'(sb.pop_front());
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = a;
        bus.divisor = b;
        @(posedge clk);
        #1;
        sb.push_back(model(a, b, cyc));
        @(negedge clk);
        bus.start = 1'b0;
        bus.dividend = $urandom;
        bus.divisor = 16'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("wait_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_dvd(input logic [15:0] b);
        logic [15:0] hi;
        hi = 16'($urandom_range(0, int'(b) - 1));
        return {hi, 16'($urandom)};
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] b;
        logic [31:0] a;
        logic [15:0] nb;
        logic [31:0] na;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        last_q = '0;
        #1;
        check("reset_outputs", 64'({bus.busy, bus.done, bus.quotient, bus.remainder, bus.ovf}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        issue(32'd100, 16'd7);              wait_idle();
        issue(32'hFFFE0001, 16'hFFFF);      wait_idle();
        issue(32'd12345, 16'd0);            wait_idle();
        issue(32'h00010000, 16'd1);         wait_idle();
        issue(32'hFFFFFFFF, 16'hFFFF);      wait_idle();
        issue(32'h0000FFFF, 16'd1);         wait_idle();
        issue(32'd5, 16'd7);                wait_idle();
        issue(32'd0, 16'd5);                wait_idle();
        issue(32'hFFFEFFFF, 16'hFFFF);      wait_idle();

        // Start during CALC is ignored; outputs hold the previous result meanwhile.
        issue(32'd1000000, 16'd333);
        repeat (4) @(negedge clk);
        check("hold_quotient", 64'(bus.quotient), 64'(last_q));
        bus.start = 1'b1;
        bus.dividend = 32'd77;
        bus.divisor = 16'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // Reset mid-CALC aborts; start present as reset releases is taken normally.
        issue(32'd50000, 16'd3);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", 64'({bus.busy, bus.done, bus.quotient, bus.remainder, bus.ovf}), 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor = 16'd10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(model(32'd1000, 16'd10, cyc));
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // Random single operations, some overflowing.
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                b = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom);
                a = $urandom;
            end else begin
                b = 16'($urandom_range(1, 65535));
                a = rand_dvd(b);
            end
            issue(a, b);
            wait_idle();
        end

        // Back-to-back with start held; operands churn while CALC runs.
        b = 16'($urandom_range(1, 65535));
        a = rand_dvd(b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = a;
        bus.divisor = b;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk);
            #1;
            sb.push_back(model(a, b, cyc));
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                bus.dividend = $urandom;
                bus.divisor = 16'($urandom);
            end
            @(negedge clk);
            nb = 16'($urandom_range(1, 65535));
            na = rand_dvd(nb);
            a = na;
            b = nb;
            bus.dividend = a;
            bus.divisor = b;
            if (k == 1999) bus.start = 1'b0;
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
